// File: rtl/qam_ctrl_pkg.sv
// qam_ctrl_pkg: shared state encoding and constants for the QAM transmit sequencer.
package qam_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WARMUP   = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    TAIL     = 3'd4
  } state_t;
  localparam int BITS_PER_SYM = 4;
  localparam logic SRC_PRE = 1'b1;
  localparam logic SRC_MSEQ = 1'b0;
endpackage

// File: rtl/clk_en_div.sv
// clk_en_div: modulo-N counter with sync clear and a registered, gated enable pulse.
module clk_en_div #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic gate,
  output logic pulse
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt, nxt;
  always_comb nxt = clr ? '0 : en ? (cnt == W'(N - 1) ? '0 : cnt + W'(1)) : cnt;
  // pulse is high in exactly the cycles where cnt sits at its terminal value and gate was granted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      cnt <= nxt;
      pulse <= gate && nxt == W'(N - 1);
    end
endmodule

// File: rtl/qam_tx_sequencer.sv
// qam_tx_sequencer: burst controller producing clock enables and gating for the QAM
// transmit chain (warm-up, preamble, payload, flush tail).
module qam_tx_sequencer #(
  parameter int BIT_DIV  = 8,
  parameter int CW_DIV   = 2,
  parameter int WARM_CYC = 16,
  parameter int PRE_SYMS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] burst_len,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       bit_en,
  output logic       sym_en,
  output logic       cw_en,
  output logic       src_sel,
  output logic       mod_en,
  output logic [2:0] state
);
  import qam_ctrl_pkg::*;
  localparam int SYM_CYC = BITS_PER_SYM * BIT_DIV;
  localparam int CYC_MAX = WARM_CYC > SYM_CYC ? WARM_CYC : SYM_CYC;
  localparam int CYW = $clog2(CYC_MAX + 1);
  state_t cur, nxt;
  logic [CYW-1:0] cyc;
  logic [7:0] scnt, len;
  logic go, run, gate_bit;
  assign state = cur;
  assign go = cur == IDLE && start;
  assign run = cur == PREAMBLE || cur == DATA || cur == TAIL;
  assign gate_bit = nxt == PREAMBLE || nxt == DATA;
  // symbol boundaries come from sym_en, which is registered, so there is no comb loop through nxt
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:     nxt = start ? WARMUP : IDLE;
      WARMUP:   if (cyc == CYW'(WARM_CYC - 1)) nxt = PREAMBLE;
      PREAMBLE: if (sym_en && scnt == 8'(PRE_SYMS - 1)) nxt = len == 8'd0 ? TAIL : DATA;
      DATA:     if (sym_en && scnt == len - 8'd1) nxt = TAIL;
      TAIL:     if (cyc == CYW'(SYM_CYC - 1)) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort && cur != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= IDLE;
      cyc <= '0;
      scnt <= '0;
      len <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      src_sel <= 1'b0;
      mod_en <= 1'b0;
    end else begin
      cur <= nxt;
      cyc <= nxt != cur ? '0 : cyc + CYW'(1);
      scnt <= nxt != cur ? '0 : scnt + 8'(sym_en);
      if (go) len <= burst_len;
      busy <= nxt != IDLE;
      done <= cur == TAIL && nxt == IDLE && !abort;
      aborted <= abort && cur != IDLE;
      src_sel <= nxt == PREAMBLE ? SRC_PRE : SRC_MSEQ;
      mod_en <= nxt == PREAMBLE || nxt == DATA || nxt == TAIL;
    end
  clk_en_div #(.N(BIT_DIV)) u_bit (
    .clk(clk), .rst(rst), .clr(go), .en(run), .gate(gate_bit), .pulse(bit_en)
  );
  clk_en_div #(.N(SYM_CYC)) u_sym (
    .clk(clk), .rst(rst), .clr(go), .en(run), .gate(gate_bit), .pulse(sym_en)
  );
  clk_en_div #(.N(CW_DIV)) u_cw (
    .clk(clk), .rst(rst), .clr(go), .en(cur != IDLE), .gate(nxt != IDLE), .pulse(cw_en)
  );
endmodule

// File: tb/tb_qam_tx_sequencer.sv
// tb_qam_tx_sequencer: timeline-model checker plus completion-event scoreboard.
module tb_qam_tx_sequencer;
  localparam int BD = 4, CD = 2, WC = 8, PS = 2;
  localparam int SYM = 4 * BD;
  localparam int PRE_END = WC + PS * SYM;
  typedef struct {int c; bit ab; int nb; int ns;} ev_t;
  logic clk = 1'b0, rst, start, abort;
  logic [7:0] burst_len;
  logic busy, done, aborted, bit_en, sym_en, cw_en, src_sel, mod_en;
  logic [2:0] state;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int m_t0 = 0, m_len = 0, m_ab = -1, cnt_bit = 0, cnt_sym = 0;
  bit m_on = 0;
  ev_t sbq[$];
  qam_tx_sequencer #(.BIT_DIV(BD), .CW_DIV(CD), .WARM_CYC(WC), .PRE_SYMS(PS)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .bit_en(bit_en), .sym_en(sym_en),
    .cw_en(cw_en), .src_sel(src_sel), .mod_en(mod_en), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask
  function automatic int end_of(input int l);
    return PRE_END + l * SYM + SYM + 1;
  endfunction
  function automatic int ph(input int r, input int l);
    if (r < 1) return 0;
    if (r <= WC) return 1;
    if (r <= PRE_END) return 2;
    if (r <= PRE_END + l * SYM) return 3;
    if (r < end_of(l)) return 4;
    return 0;
  endfunction
  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
    chk({tag, "_en"}, 32'({bit_en, sym_en, cw_en}), 0);
    chk({tag, "_src_mod"}, 32'({src_sel, mod_en}), 0);
  endtask
  always @(negedge clk) begin
    int r, es;
    bit ed, ea, eb, esy, ecw;
    ev_t e;
    if (rst) begin
      m_on = 0;
      m_ab = -1;
      sbq.delete();
    end else begin
      r = cyc - m_t0;
      es = 0; ed = 0; ea = 0; eb = 0; esy = 0; ecw = 0;
      if (m_ab >= 0 && cyc == m_ab + 1) ea = 1;
      else if (m_on) begin
        es = ph(r, m_len);
        ed = r == end_of(m_len);
        eb = (es == 2 || es == 3) && (r - WC - 1) % BD == BD - 1;
        esy = (es == 2 || es == 3) && (r - WC - 1) % SYM == SYM - 1;
        ecw = es != 0 && r % CD == 0;
      end
      chk("state", 32'(state), 32'(es));
      chk("busy", 32'(busy), 32'(es != 0));
      chk("done", 32'(done), 32'(ed));
      chk("aborted", 32'(aborted), 32'(ea));
      chk("bit_en", 32'(bit_en), 32'(eb));
      chk("sym_en", 32'(sym_en), 32'(esy));
      chk("cw_en", 32'(cw_en), 32'(ecw));
      chk("src_sel", 32'(src_sel), 32'(es == 2));
      chk("mod_en", 32'(mod_en), 32'(es >= 2));
      cnt_bit += 32'(bit_en);
      cnt_sym += 32'(sym_en);
      if (done || aborted) begin
        if (sbq.size() == 0) chk("sb_extra", 32'({done, aborted}), 0);
        else begin
          e = sbq.pop_front();
          chk("sb_end_cycle", cyc, e.c);
          chk("sb_kind", 32'({done, aborted}), e.ab ? 32'd1 : 32'd2);
          if (!e.ab) begin
            chk("sb_bit_count", cnt_bit, e.nb);
            chk("sb_sym_count", cnt_sym, e.ns);
          end
        end
      end
      // model advance for the next cycle, driven by this cycle's stimulus
      if (start && es == 0) begin
        m_on = 1; m_t0 = cyc; m_len = int'(burst_len); m_ab = -1;
        cnt_bit = 0; cnt_sym = 0;
        sbq.push_back('{cyc + end_of(m_len), 1'b0, 4 * (PS + m_len), PS + m_len});
      end else if (abort && es != 0) begin
        m_ab = cyc; m_on = 0;
        if (sbq.size() > 0) void'(sbq.pop_back());
        sbq.push_back('{cyc + 1, 1'b1, 0, 0});
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask
  task automatic go(input logic [7:0] l);
    start = 1'b1;
    burst_len = l;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; burst_len = 8'd0;
    repeat (3) step();
    chk_idle("reset");
    rst = 1'b0;
    repeat (2) step();
    go(8'd3);
    for (int i = 1; i <= 105; i++) begin
      step();
      if (i == 105) go(8'd3);
    end
    for (int i = 1; i <= 110; i++) begin
      step();
      if (i == 20 || i == 60) start = 1'b1;
      if (i == 30) burst_len = 8'd9;
    end
    go(8'd0);
    repeat (62) step();
    go(8'd3);
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 50) abort = 1'b1;
    end
    abort = 1'b1;
    repeat (2) step();
    go(8'd1);
    abort = 1'b1;
    repeat (80) step();
    go(8'd2);
    repeat (30) step();
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
